// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 constants: widths, reset PC, NOP, opcodes, fetch states
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - in-order buffer of fetched {instr, pc} pairs; flush beats push
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [31:0]              push_instr,
  input  logic [XLEN-1:0]          push_pc,
  input  logic                     pop,
  output logic [31:0]              head_instr,
  output logic [XLEN-1:0]          head_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      instr_mem[wr_ptr] <= push_instr;
      pc_mem[wr_ptr]    <= push_pc;
    end
  end

  assign head_instr = instr_mem[rd_ptr];
  assign head_pc    = pc_mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and imem requester feeding decode through an in-order buffer
module fetch_unit
  import riscv_pkg::fetch_state_e, riscv_pkg::FETCH, riscv_pkg::FLUSH, riscv_pkg::NOP_INSTR;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [31:0]     dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_pc_plus4
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] hold_pc;
  logic [XLEN-1:0] target_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   drop_next;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic [31:0]     head_instr;
  logic [XLEN-1:0] head_pc;
  logic            pop;
  logic            accept;
  logic            resp_fire;
  logic            push;
  logic            unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];
  assign target_pc      = {redirect_pc[XLEN-1:2], 2'b00};

  assign dec_valid = (count != '0);
  assign pop       = dec_valid & dec_ready;
  assign resp_fire = imem_resp_valid & ~reset;
  assign accept    = imem_req_valid & imem_req_ready;
  assign push      = resp_fire & (state == FETCH);
  assign occupancy = {1'b0, outstanding} + {1'b0, count} - (CW + 1)'(pop);

  assign imem_req_addr = pc;

  always_comb begin
    state_next     = state;
    drop_next      = drop;
    imem_req_valid = 1'b0;
    if (redirect) begin
      // Everything still in flight becomes stale; a response landing now is already gone.
      drop_next  = outstanding - CW'(resp_fire);
      state_next = (drop_next != '0) ? FLUSH : FETCH;
    end else begin
      case (state)
        FETCH: imem_req_valid = (occupancy < DEPTH_W);
        FLUSH: begin
          if (resp_fire) drop_next = drop - CW'(1);
          if (drop_next == '0) state_next = FETCH;
        end
      endcase
    end
    if (reset) imem_req_valid = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      hold_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      state       <= state_next;
      drop        <= drop_next;
      outstanding <= outstanding + CW'(accept) - CW'(resp_fire);
      if (redirect) begin
        pc      <= target_pc;
        resp_pc <= target_pc;
      end else begin
        if (accept) pc      <= pc + XLEN'(4);
        if (push)   resp_pc <= resp_pc + XLEN'(4);
      end
      if (dec_valid) hold_pc <= head_pc;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .push       (push),
    .push_instr (imem_resp_data),
    .push_pc    (resp_pc),
    .pop        (pop),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .count      (count)
  );

  assign dec_instr    = dec_valid ? head_instr : NOP_INSTR;
  assign dec_pc       = dec_valid ? head_pc : hold_pc;
  assign dec_pc_plus4 = dec_pc + XLEN'(4);

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the main decoder. It owns the PC register and issues word requests to instruction memory through a valid/ready handshake. Returned instructions go into a small in-order buffer and are presented to decode as {instr, pc, pc+4} with a valid/ready handshake. Branch/jump redirects from execute flush the buffer and discard in-flight responses.

Parameters:
XLEN, 32, width of PC and addresses
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 2, instruction buffer entries; also the maximum number of in-flight requests plus buffered instructions (power of 2, ≥2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word address, bits[1:0] always 0
imem_resp_valid  in  1  response valid; responses return in order, one per accepted request, latency ≥1 cycle
imem_resp_data  in  32  instruction word
redirect  in  1  taken branch/jump (PCSrc)
redirect_pc  in  XLEN  target (PCTarget)
dec_valid  out  1  instruction available to decode
dec_ready  in  1  decode accepts
dec_instr  out  32  instruction; its opcode field [6:0] feeds the decoder Opc
dec_pc  out  XLEN  PC of dec_instr
dec_pc_plus4  out  XLEN  dec_pc + 4, modulo 2^XLEN

Behaviour:
- Reset (sync, active-high, dominates everything): pc←RESET_PC, buffer empty, outstanding←0, drop←0, state←FETCH. Outputs during and after reset: imem_req_valid=0 while reset is high, imem_req_addr=RESET_PC, dec_valid=0, dec_instr=32'h0000_0013 (NOP), dec_pc=RESET_PC, dec_pc_plus4=RESET_PC+4. Responses arriving while reset is high are ignored. The memory shares this reset.
- Counters: outstanding counts accepted requests with no response yet; count is buffer occupancy.
- pop = dec_valid & dec_ready.
- Issue condition (FETCH only): outstanding + count − pop < DEPTH → imem_req_valid=1 and imem_req_addr=pc. On accept (valid & ready), pc←pc+4, wrapping modulo 2^XLEN. A request that is not accepted must hold its addr stable until accepted, unless redirect or reset occurs.
- Response in FETCH: push {imem_resp_data, pc of that request} into the buffer. A per-entry PC queue tracks in-flight PCs. Occupancy never exceeds DEPTH by construction. Push and pop in the same cycle are allowed.
- Timing: dec_valid = (count≠0). All dec_* outputs are registered buffer heads. Response in cycle N gives dec_valid in N+1. With 1-cycle memory and dec_ready=1, steady throughput is 1 instruction/cycle.
- When the buffer is empty, dec_instr=NOP and dec_pc/dec_pc_plus4 hold their last values.
- FSM states:
  - FETCH: normal operation.
  - FLUSH: discard responses until drop==0; no requests issued.
- redirect=1, any state, has highest priority after reset:
  - buffer cleared (a same-cycle pop is harmless);
  - pc←{redirect_pc[XLEN-1:2],2'b00};
  - drop←outstanding, including a request accepted this cycle, minus any response arriving this cycle;
  - state←FLUSH if that drop>0, else FETCH;
  - imem_req_valid is forced to 0 that cycle;
  - dec_valid=0 in the following cycle.
- FLUSH: each resp_valid decrements drop and the data is discarded. When drop reaches 0, including on the final response, the next state is FETCH and the first request to redirect_pc issues that next cycle. A new redirect in FLUSH re-applies the redirect rule; drop is recomputed, not accumulated.
- A redirect while imem_req_valid=1 and not yet accepted abandons that request; it is never accepted.

Decomposition:
- Shared package riscv_pkg:
  - XLEN, RESET_PC, NOP_INSTR=32'h0000_0013;
  - opcode constants (OPC_LOAD 7'b0000011, OPC_STORE 7'b0100011, OPC_RTYPE 7'b0110011, OPC_BRANCH 7'b1100011, OPC_ITYPE 7'b0010011, OPC_JAL 7'b1101111, OPC_LUI 7'b0110111), shared with the decoder;
  - fetch state encoding FETCH/FLUSH.
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO of {instr, pc}, with push/pop/flush and count outputs; flush has priority over push.

Test Plan:
1. Reset held 3 cycles then released, imem 1-cycle latency, always ready, dec_ready=1 → first req addr 0x0 in the cycle after release; dec_valid with dec_pc=0x0 two cycles later; then pcs 0x4, 0x8, 0xC on consecutive cycles with pc_plus4 correct.
2. dec_ready=0 for 5 cycles → at most DEPTH requests beyond consumed ones; no instruction lost or duplicated; output order is intact after dec_ready=1.
3. imem_req_ready=0 for 4 cycles → imem_req_addr stable at 0x8 throughout; accepted exactly once.
4. Redirect to 0x103 with 2 requests outstanding, 3-cycle memory latency → dec_valid=0 next cycle; both stale responses dropped; next request addr 0x100; first delivered dec_pc=0x100.
5. Redirect in the same cycle as a response and as a pop, with 1 outstanding → drop=0, FLUSH skipped, the response is not delivered, new fetch issues next cycle.
6. RESET_PC=32'hFFFF_FFFC → second fetch addr 0x0 (wrap); dec_pc_plus4=0x0 for the first instruction.
